// File: rtl/pixel_pack_writer_if.sv
// Pixel-in / frame-buffer-write bundle for pixel_pack_writer.
// The slave modport is the packer; the master side feeds pixels and watches the writes.
interface pixel_pack_writer_if #(
    parameter int WORD_W = 8,
    parameter int ADDR_W = 13
);
    logic              frame_start;
    logic              pix_de;
    logic [7:0]        pix_data;
    logic              we;
    logic [WORD_W-1:0] wData;
    logic [ADDR_W-1:0] wAddr;
    logic              frame_tick;
    logic              busy;
    logic              err_overrun;

    modport master (
        output frame_start, pix_de, pix_data,
        input  we, wData, wAddr, frame_tick, busy, err_overrun
    );

    modport slave (
        input  frame_start, pix_de, pix_data,
        output we, wData, wAddr, frame_tick, busy, err_overrun
    );
endinterface

// File: rtl/pixel_pack_writer.sv
// Packs PIX_W-bit pixels into WORD_W-bit words, pads each line end with zeros,
// and writes the words to consecutive frame buffer addresses.
module pixel_pack_writer #(
    parameter int PIX_W      = 1,
    parameter int WORD_W     = 8,
    parameter int IMG_W      = 320,
    parameter int IMG_H      = 132,
    parameter bit MSB_FIRST  = 1'b0,
    parameter bit AUTO_REARM = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    pixel_pack_writer_if.slave  bus
);
    localparam int PPW    = WORD_W / PIX_W;
    localparam int WPL    = (IMG_W + PPW - 1) / PPW;
    localparam int DEPTH  = WPL * IMG_H;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int SLOT_W = (PPW > 1) ? $clog2(PPW) : 1;
    localparam int COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W  = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    typedef enum logic [1:0] {S_IDLE, S_PACK, S_DONE} state_t;

    state_t              r_state, w_state;
    logic [SLOT_W-1:0]   r_slot, w_slot;
    logic [COL_W-1:0]    r_col, w_col;
    logic [ROW_W-1:0]    r_row, w_row;
    logic [ADDR_W-1:0]   r_addr, w_addr;
    logic [WORD_W-1:0]   r_acc, w_acc;
    logic                r_we, w_we;
    logic [WORD_W-1:0]   r_wdata, w_wdata;
    logic [ADDR_W-1:0]   r_waddr, w_waddr;
    logic                r_tick, w_tick;
    logic                r_busy, w_busy;
    logic                r_err, w_err;
    logic [WORD_W-1:0]   w_word;
    logic                w_accept, w_commit, w_eol, w_last;
    int                  w_shift;
    logic                w_unused;

    // Only the low PIX_W bits of a pixel carry information.
    assign w_unused = ^bus.pix_data;

    always_comb begin
        w_state  = r_state;
        w_slot   = r_slot;
        w_col    = r_col;
        w_row    = r_row;
        w_addr   = r_addr;
        w_acc    = r_acc;
        w_we     = 1'b0;
        w_wdata  = r_wdata;
        w_waddr  = r_waddr;
        w_tick   = 1'b0;
        w_busy   = r_busy;
        w_err    = r_err;
        w_word   = '0;
        w_shift  = 0;
        w_accept = 1'b0;
        w_commit = 1'b0;
        w_eol    = 1'b0;
        w_last   = 1'b0;

        // frame_start is applied first so a pixel in the same cycle lands as pixel 0.
        if (bus.frame_start) begin
            w_state = S_IDLE;
            w_slot  = '0;
            w_col   = '0;
            w_row   = '0;
            w_addr  = '0;
            w_acc   = '0;
            w_err   = 1'b0;
            w_busy  = 1'b0;
        end

        w_accept = bus.pix_de && (w_state != S_DONE);
        if (bus.pix_de && (w_state == S_DONE)) begin
            w_err = 1'b1;
        end

        if (w_accept) begin
            w_shift  = MSB_FIRST ? ((PPW - 1) - int'(w_slot)) * PIX_W : int'(w_slot) * PIX_W;
            w_word   = w_acc | (WORD_W'(bus.pix_data[PIX_W-1:0]) << w_shift);
            w_eol    = (w_col == COL_W'(IMG_W - 1));
            w_last   = w_eol && (w_row == ROW_W'(IMG_H - 1));
            w_commit = (w_slot == SLOT_W'(PPW - 1)) || w_eol;
            w_state  = S_PACK;
            w_busy   = 1'b1;

            if (w_commit) begin
                w_we    = 1'b1;
                w_wdata = w_word;
                w_waddr = w_addr;
                w_tick  = w_last;
                w_slot  = '0;
                w_acc   = '0;
                w_addr  = w_last ? '0 : w_addr + ADDR_W'(1);
            end else begin
                w_slot  = w_slot + SLOT_W'(1);
                w_acc   = w_word;
            end

            if (w_eol) begin
                w_col = '0;
                w_row = w_last ? '0 : w_row + ROW_W'(1);
            end else begin
                w_col = w_col + COL_W'(1);
            end

            if (w_last) begin
                w_state = AUTO_REARM ? S_IDLE : S_DONE;
                w_busy  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_slot  <= '0;
            r_col   <= '0;
            r_row   <= '0;
            r_addr  <= '0;
            r_acc   <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_waddr <= '0;
            r_tick  <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_slot  <= w_slot;
            r_col   <= w_col;
            r_row   <= w_row;
            r_addr  <= w_addr;
            r_acc   <= w_acc;
            r_we    <= w_we;
            r_wdata <= w_wdata;
            r_waddr <= w_waddr;
            r_tick  <= w_tick;
            r_busy  <= w_busy;
            r_err   <= w_err;
        end
    end

    assign bus.we          = r_we;
    assign bus.wData       = r_wdata;
    assign bus.wAddr       = r_waddr;
    assign bus.frame_tick  = r_tick;
    assign bus.busy        = r_busy;
    assign bus.err_overrun = r_err;
endmodule
